// File: rtl/moore_det_pkg.sv
// Shared types for the run-length detector: FSM state encoding
// and detection-mode constants.
package moore_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DET  = 2'b10
  } state_t;

  localparam logic MODE_OVERLAP    = 1'b0;
  localparam logic MODE_NONOVERLAP = 1'b1;

endpackage

// File: rtl/moore_run_detector_if.sv
// Bit-stream bundle for moore_run_detector.
// master: in_valid/inp/mode/clr_count out; slave: out/run_bit/run_len/det_count out.
interface moore_run_detector_if #(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(RUN_LEN + 1)
);
  logic             in_valid;
  logic             inp;
  logic             mode;
  logic             clr_count;
  logic             out;
  logic             run_bit;
  logic [LEN_W-1:0] run_len;
  logic [CNT_W-1:0] det_count;

  modport master (
    output in_valid,
    output inp,
    output mode,
    output clr_count,
    input  out,
    input  run_bit,
    input  run_len,
    input  det_count
  );

  modport slave (
    input  in_valid,
    input  inp,
    input  mode,
    input  clr_count,
    output out,
    output run_bit,
    output run_len,
    output det_count
  );
endinterface

// File: rtl/moore_run_detector_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Ports: clk, rst (sync, active high), i_inc, i_clr -> o_count[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);
  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_cnt;
  logic         w_full;

  assign w_full = (r_cnt == MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_full) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_count = r_cnt;
endmodule

// File: rtl/moore_run_detector.sv
// Moore run-length detector: out high while the last RUN_LEN accepted bits match.
// Ports: clk, rst (sync, active high), bus (slave side of moore_run_detector_if).
module moore_run_detector
  import moore_det_pkg::*;
#(
  parameter  int RUN_LEN = 2,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(RUN_LEN + 1)
) (
  input logic                 clk,
  input logic                 rst,
  moore_run_detector_if.slave bus
);
  localparam logic [LEN_W-1:0] FULL = LEN_W'(RUN_LEN);
  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_run_bit;
  logic             w_run_bit_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_nxt;
  logic             w_same;
  logic             w_det_evt;
  logic [CNT_W-1:0] w_count;

  assign w_same = (bus.inp == r_run_bit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_run_bit <= 1'b0;
      r_len     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_run_bit <= w_run_bit_nxt;
      r_len     <= w_len_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_run_bit_nxt = r_run_bit;
    w_len_nxt     = r_len;
    w_det_evt     = 1'b0;
    if (bus.in_valid) begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt   = RUN;
          w_run_bit_nxt = bus.inp;
          w_len_nxt     = ONE;
        end
        RUN: begin
          if (!w_same) begin
            w_run_bit_nxt = bus.inp;
            w_len_nxt     = ONE;
          end else if (r_len == FULL - ONE) begin
            w_state_nxt = DET;
            w_len_nxt   = FULL;
            w_det_evt   = 1'b1;
          end else begin
            w_len_nxt = r_len + ONE;
          end
        end
        DET: begin
          if (!w_same) begin
            w_state_nxt   = RUN;
            w_run_bit_nxt = bus.inp;
            w_len_nxt     = ONE;
          end else if (bus.mode == MODE_OVERLAP) begin
            w_det_evt = 1'b1;
          end else begin
            // matched bits are consumed; start a fresh run
            w_state_nxt = RUN;
            w_len_nxt   = ONE;
          end
        end
        default: begin
          w_state_nxt   = IDLE;
          w_run_bit_nxt = 1'b0;
          w_len_nxt     = '0;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_det_evt),
    .i_clr  (bus.clr_count),
    .o_count(w_count)
  );

  assign bus.out       = (r_state == DET);
  assign bus.run_bit   = r_run_bit;
  assign bus.run_len   = r_len;
  assign bus.det_count = w_count;
endmodule

// File: tb/tb_moore_run_detector.sv
// Testbench: three detector configurations, directed vector table
// plus randomized stream checked against a run-length model.
module tb_moore_run_detector;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s_vld = 1'b0;
  logic s_inp = 1'b0;
  logic s_md = 1'b0;
  logic s_clr = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  moore_run_detector_if #(.RUN_LEN(2), .CNT_W(8)) b0 ();
  moore_run_detector_if #(.RUN_LEN(3), .CNT_W(8)) b1 ();
  moore_run_detector_if #(.RUN_LEN(2), .CNT_W(2)) b2 ();

  assign b0.in_valid = s_vld;
  assign b0.inp = s_inp;
  assign b0.mode = s_md;
  assign b0.clr_count = s_clr;
  assign b1.in_valid = s_vld;
  assign b1.inp = s_inp;
  assign b1.mode = s_md;
  assign b1.clr_count = s_clr;
  assign b2.in_valid = s_vld;
  assign b2.inp = s_inp;
  assign b2.mode = s_md;
  assign b2.clr_count = s_clr;

  moore_run_detector #(.RUN_LEN(2), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  moore_run_detector #(.RUN_LEN(3), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  moore_run_detector #(.RUN_LEN(2), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  typedef struct {
    bit r;
    bit v;
    bit i;
    bit m;
    bit c;
    int d;
    bit e_out;
    bit e_rb;
    int e_len;
    int e_cnt;
  } vec_t;

  vec_t vq[$];

  // model state per configuration
  int R[3] = '{2, 3, 2};
  int MAXC[3] = '{255, 255, 3};
  int eq_run[3];
  int seg_off[3];
  int m_bit[3];
  int m_len[3];
  int m_cnt[3];

  task automatic add(input bit r, input bit v, input bit i,
                     input bit m, input bit c, input int d,
                     input bit eo, input bit eb,
                     input int el, input int ec);
    vec_t x;
    x.r = r; x.v = v; x.i = i; x.m = m; x.c = c; x.d = d;
    x.e_out = eo; x.e_rb = eb; x.e_len = el; x.e_cnt = ec;
    vq.push_back(x);
  endtask

  task automatic chk(input string nm, input int d,
                     input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, expected %0d",
               nm, d, act, exp);
    end
  endtask

  task automatic rd(input int d, output int o, output int rb,
                    output int ln, output int ct);
    case (d)
      0: begin
        o = int'(b0.out); rb = int'(b0.run_bit);
        ln = int'(b0.run_len); ct = int'(b0.det_count);
      end
      1: begin
        o = int'(b1.out); rb = int'(b1.run_bit);
        ln = int'(b1.run_len); ct = int'(b1.det_count);
      end
      default: begin
        o = int'(b2.out); rb = int'(b2.run_bit);
        ln = int'(b2.run_len); ct = int'(b2.det_count);
      end
    endcase
  endtask

  task automatic step(input bit r, input bit v, input bit i,
                      input bit m, input bit c);
    rst = r; s_vld = v; s_inp = i; s_md = m; s_clr = c;
    @(posedge clk);
    #1;
  endtask

  // run length = equal bits since the start of the current
  // segment; non-overlap starts a new segment past RUN_LEN
  task automatic mdl(input int d, input bit r, input bit v,
                     input bit i, input bit m, input bit c);
    bit evt;
    int ln;
    evt = 1'b0;
    if (r) begin
      eq_run[d] = 0; seg_off[d] = 0; m_bit[d] = 0;
      m_len[d] = 0; m_cnt[d] = 0;
      return;
    end
    if (v) begin
      if (eq_run[d] == 0 || int'(i) != m_bit[d]) begin
        eq_run[d] = 1; seg_off[d] = 0; m_bit[d] = int'(i);
      end else begin
        eq_run[d]++;
        if (eq_run[d] - seg_off[d] > R[d] && m)
          seg_off[d] = eq_run[d] - 1;
      end
      ln = eq_run[d] - seg_off[d];
      m_len[d] = (ln > R[d]) ? R[d] : ln;
      evt = (m_len[d] == R[d]);
    end
    if (c) m_cnt[d] = 0;
    else if (evt && m_cnt[d] < MAXC[d]) m_cnt[d]++;
  endtask

  initial begin
    int o, rb, ln, ct;
    bit r, v, i, m, c;

    // RUN_LEN=2 overlap: 1,1,1,0,0
    add(1,1,1,0,0, 0, 0,0,0,0);
    add(0,1,1,0,0, 0, 0,1,1,0);
    add(0,1,1,0,0, 0, 1,1,2,1);
    add(0,1,1,0,0, 0, 1,1,2,2);
    add(0,1,0,0,0, 0, 0,0,1,2);
    add(0,1,0,0,0, 0, 1,0,2,3);
    // RUN_LEN=3 non-overlap: six 1s
    add(1,0,0,1,0, 1, 0,0,0,0);
    add(0,1,1,1,0, 1, 0,1,1,0);
    add(0,1,1,1,0, 1, 0,1,2,0);
    add(0,1,1,1,0, 1, 1,1,3,1);
    add(0,1,1,1,0, 1, 0,1,1,1);
    add(0,1,1,1,0, 1, 0,1,2,1);
    add(0,1,1,1,0, 1, 1,1,3,2);
    // valid gating gap
    add(1,0,0,0,0, 0, 0,0,0,0);
    add(0,1,0,0,0, 0, 0,0,1,0);
    add(0,0,1,0,0, 0, 0,0,1,0);
    add(0,0,0,0,0, 0, 0,0,1,0);
    add(0,0,1,0,0, 0, 0,0,1,0);
    add(0,1,0,0,0, 0, 1,0,2,1);
    // reset mid-run overrides a valid bit
    add(1,0,0,0,0, 1, 0,0,0,0);
    add(0,1,1,0,0, 1, 0,1,1,0);
    add(0,1,1,0,0, 1, 0,1,2,0);
    add(1,1,1,0,0, 1, 0,0,0,0);
    add(0,1,1,0,0, 1, 0,1,1,0);
    // 2-bit counter saturation, then clear wins over event
    add(1,0,0,0,0, 2, 0,0,0,0);
    add(0,1,1,0,0, 2, 0,1,1,0);
    add(0,1,1,0,0, 2, 1,1,2,1);
    add(0,1,1,0,0, 2, 1,1,2,2);
    add(0,1,1,0,0, 2, 1,1,2,3);
    add(0,1,1,0,0, 2, 1,1,2,3);
    add(0,1,1,0,0, 2, 1,1,2,3);
    add(0,1,1,0,1, 2, 1,1,2,0);

    foreach (vq[k]) begin
      step(vq[k].r, vq[k].v, vq[k].i, vq[k].m, vq[k].c);
      rd(vq[k].d, o, rb, ln, ct);
      chk($sformatf("vec%0d.out", k), vq[k].d, o, int'(vq[k].e_out));
      chk($sformatf("vec%0d.run_bit", k), vq[k].d, rb, int'(vq[k].e_rb));
      chk($sformatf("vec%0d.run_len", k), vq[k].d, ln, vq[k].e_len);
      chk($sformatf("vec%0d.det_count", k), vq[k].d, ct, vq[k].e_cnt);
    end

    // randomized stream, all three configurations at once
    i = 1'b0;
    m = 1'b0;
    step(1, 0, 0, 0, 0);
    for (int d = 0; d < 3; d++) mdl(d, 1, 0, 0, 0, 0);
    for (int k = 0; k < 1000; k++) begin
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 3) i = ~i;
      if ($urandom_range(0, 24) == 0) m = ~m;
      c = ($urandom_range(0, 29) == 0);
      step(r, v, i, m, c);
      for (int d = 0; d < 3; d++) begin
        mdl(d, r, v, i, m, c);
        rd(d, o, rb, ln, ct);
        chk($sformatf("rnd%0d.out", k), d, o,
            int'(m_len[d] == R[d]));
        chk($sformatf("rnd%0d.run_bit", k), d, rb, m_bit[d]);
        chk($sformatf("rnd%0d.run_len", k), d, ln, m_len[d]);
        chk($sformatf("rnd%0d.det_count", k), d, ct, m_cnt[d]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/moore_run_detector.md
# moore_run_detector

Parametrised Moore-style run-length detector for a serial bit stream. It asserts `out` while the last `RUN_LEN` accepted bits are all equal, whether all 0s or all 1s. It supports overlapping and non-overlapping detection modes, input-valid gating, and a saturating detection counter. It sits on a serial input path, feeds alignment and monitoring logic, and generalises the team's fixed two-bit equal-run detector.

## Interface
- `RUN_LEN`, default 2: run length that triggers detection; legal range 2..255.
- `CNT_W`, default 8: width of `det_count`.
- `LEN_W`, default `$clog2(RUN_LEN+1)`: width of `run_len`; derived, never overridden.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `inp` is accepted on this edge.
- `inp`  in  1  serial data bit.
- `mode`  in  1  0 = overlapping detection, 1 = non-overlapping detection.
- `clr_count`  in  1  synchronous clear of `det_count`.
- `out`  out  1  high iff the FSM is in DET.
- `run_bit`  out  1  value of the current run.
- `run_len`  out  LEN_W  current run length, saturating at `RUN_LEN`.
- `det_count`  out  CNT_W  number of detections, saturating.

## Operation
- States:
  - IDLE: no bit accepted since reset.
  - RUN: run length is 1..RUN_LEN-1.
  - DET: run length equals RUN_LEN.
- Reset values: state IDLE, `out`=0, `run_bit`=0, `run_len`=0, `det_count`=0.
- `in_valid`=0: all state, `run_bit`, `run_len` and `out` hold. `det_count` changes only through `clr_count`.
- Transitions on an accepted bit (`in_valid`=1):
  - IDLE → RUN; `run_bit`=`inp`, `run_len`=1.
  - RUN or DET, `inp`≠`run_bit` → RUN; `run_bit`=`inp`, `run_len`=1.
  - RUN, `inp`=`run_bit`: `run_len`+1. On reaching RUN_LEN → DET, and this is a detection event.
  - DET, `inp`=`run_bit`, `mode`=0 → stay in DET; `run_len` stays RUN_LEN; detection event.
  - DET, `inp`=`run_bit`, `mode`=1 → RUN; `run_len`=1, so a new run begins and bits are not reused.
- `mode` is sampled on each accepted bit; a change mid-run applies from the next accepted bit.
- Detection counter:
  - Each detection event increments `det_count`.
  - The counter saturates at 2^CNT_W−1 and never wraps.
  - `clr_count`=1 forces `det_count` to 0. If a detection event occurs on the same edge, the clear wins.
- `out` is a pure decode of the state register, with no dependency on `inp`.

## Timing
- Latency: the bit accepted on edge k is reflected in `out`, `run_len` and `run_bit` immediately after edge k. Zero extra register stage.
- `det_count` updates on the same edge as the detection event.
- `rst` overrides every input on the same edge, including mid-run and in DET. `out` is 0 after that edge.
- In non-overlapping mode, for a constant input, `out` pulses for exactly one accepted bit every `RUN_LEN` accepted bits.
- No backpressure: every bit with `in_valid`=1 is consumed.

## Structure
- Shared package `moore_det_pkg` holds:
  - the state typedef (IDLE, RUN, DET), 2-bit encoding 00/01/10;
  - the mode constants `MODE_OVERLAP`=0 and `MODE_NONOVERLAP`=1.
- Sub-module `sat_counter`, parametrised by width, with `inc` and `clr` inputs (clear has priority). It is instantiated for `det_count`.
- The FSM and the run-length counter stay in the top module.

## Test plan
- RUN_LEN=2, mode=0, `in_valid`=1, `inp`=1,1,1,0,0 → `out`=0,1,1,0,1; `run_len`=1,2,2,1,2; `det_count` ends at 3.
- RUN_LEN=3, mode=1, `inp`=1,1,1,1,1,1 → `out`=0,0,1,0,0,1; `det_count` ends at 2.
- RUN_LEN=2, `inp`=0 (valid), then 3 cycles with `in_valid`=0 and `inp` toggling, then `inp`=0 (valid) → `out` stays 0 during the gap and is 1 after the second valid bit.
- RUN_LEN=3, `inp`=1,1, then `rst` for one cycle, then `inp`=1 → after reset `out`=0 and `run_len`=0; after the next bit `run_len`=1 and `out`=0.
- CNT_W=2, mode=0, RUN_LEN=2, six consecutive valid 1s (five detection events) → `det_count` saturates at 3. Then assert `clr_count` together with a further valid 1 → `det_count`=0 and `out`=1.
